// File: rtl/eth_tx_sched.sv
// Paces eth_tx frame starts: inter-frame gap, busy watchdog, and idle-line link pulses.
// Latency: frm_req seen at tick N -> tx_start/frm_ack at tick N+1; a request waits in IDLE until served.
module eth_tx_sched #(
    parameter int unsigned IFG_TICKS    = 96,
    parameter int unsigned NLP_PERIOD   = 160000,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eth_clk_en,
    input  logic        frm_req,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic        frm_ack,
    output logic        nlp,
    output logic [15:0] seq,
    output logic        tx_err
);
    localparam int GAP_W = (IFG_TICKS > 1) ? $clog2(IFG_TICKS) : 1;
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [17:0]      NLP_LAST = 18'(NLP_PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_TICKS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, BUSY, GAP, NLP} state_t;

    state_t           state_q, state_d;
    logic [17:0]      nlp_tmr_q, nlp_tmr_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]      seq_q, seq_d;
    logic             tx_start_q, tx_start_d;
    logic             nlp_q, nlp_d;
    logic             tx_err_q, tx_err_d;
    logic             nlp_expired;

    assign nlp_expired = (nlp_tmr_q == NLP_LAST);

    always_comb begin
        state_d    = state_q;
        nlp_tmr_d  = nlp_tmr_q;
        gap_cnt_d  = gap_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        seq_d      = seq_q;
        tx_err_d   = tx_err_q;
        tx_start_d = tx_start_q;
        nlp_d      = nlp_q;
        if (eth_clk_en) begin
            tx_start_d = 1'b0;
            nlp_d      = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!nlp_expired) nlp_tmr_d = nlp_tmr_q + 18'd1;
                    // A waiting frame pre-empts a due link pulse; START clears the timer.
                    if (frm_req) begin
                        state_d    = START;
                        tx_start_d = 1'b1;
                    end else if (nlp_expired) begin
                        state_d = NLP;
                        nlp_d   = 1'b1;
                    end
                end
                START: begin
                    seq_d     = seq_q + 16'd1;
                    nlp_tmr_d = '0;
                    // The START tick itself already counts as a tick without tx_busy.
                    tmo_cnt_d = TMO_W'(1);
                    state_d   = WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_d = BUSY;
                    end else if (tmo_cnt_q >= TMO_LAST) begin
                        tx_err_d  = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end
                BUSY: begin
                    if (!tx_busy) begin
                        nlp_tmr_d = '0;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
                GAP: begin
                    if (!nlp_expired) nlp_tmr_d = nlp_tmr_q + 18'd1;
                    if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                    else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
                NLP: begin
                    nlp_tmr_d = '0;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            nlp_tmr_q  <= '0;
            gap_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            seq_q      <= '0;
            tx_start_q <= 1'b0;
            nlp_q      <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            nlp_tmr_q  <= nlp_tmr_d;
            gap_cnt_q  <= gap_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            seq_q      <= seq_d;
            tx_start_q <= tx_start_d;
            nlp_q      <= nlp_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign tx_start = tx_start_q;
    assign frm_ack  = tx_start_q;
    assign nlp      = nlp_q;
    assign seq      = seq_q;
    assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: expected pulse ticks and sequence numbers come from closed-form timing rules.
module tb_eth_tx_sched;
    localparam int IFG  = 4;
    localparam int NLPP = 20;
    localparam int BTO  = 3;
    // Model transmitter: tx_busy rises 2 ticks after tx_start and stays up for 10 ticks.
    localparam int BUSY_DLY = 2;
    localparam int BUSY_LEN = 10;
    localparam int FRAME_PERIOD = BUSY_DLY + BUSY_LEN + IFG + 2;
    localparam int NLP_SPACING  = NLPP + 1;
    localparam int TMO_PERIOD   = BTO + IFG + 1;

    logic        clk = 1'b0;
    logic        rst_n, eth_clk_en, frm_req, tx_busy;
    logic        tx_start, frm_ack, nlp, tx_err;
    logic [15:0] seq;

    int errors = 0;
    int checks = 0;
    int t;
    int last_start;
    bit xmit_on;

    eth_tx_sched #(.IFG_TICKS(IFG), .NLP_PERIOD(NLPP), .BUSY_TIMEOUT(BTO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .eth_clk_en (eth_clk_en),
        .frm_req    (frm_req),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .frm_ack    (frm_ack),
        .nlp        (nlp),
        .seq        (seq),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] obs_now();
        return {tx_start, frm_ack, nlp, tx_err, seq};
    endfunction

    // One tick, preceded by 0..max_gap clocks with the enable low.
    task automatic step(input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            eth_clk_en = 1'b0;
            @(negedge clk);
        end
        if (tx_start === 1'b1) last_start = t;
        tx_busy = xmit_on && (t >= last_start + BUSY_DLY) && (t < last_start + BUSY_DLY + BUSY_LEN);
        eth_clk_en = 1'b1;
        @(negedge clk);
        eth_clk_en = 1'b0;
        t++;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        eth_clk_en = 1'b0;
        frm_req    = 1'b0;
        tx_busy    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        t          = 1;
        last_start = -100;
        xmit_on    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        eth_clk_en = 1'b0;
        frm_req    = 1'b0;
        tx_busy    = 1'b0;
        repeat (2) @(negedge clk);
        eth_clk_en = 1'b1;
        frm_req    = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset tx_start: got %b want 0", tx_start); end
        checks++; if (frm_ack !== 1'b0) begin errors++; $display("FAIL reset frm_ack: got %b want 0", frm_ack); end
        checks++; if (nlp !== 1'b0) begin errors++; $display("FAIL reset nlp: got %b want 0", nlp); end
        checks++; if (tx_err !== 1'b0) begin errors++; $display("FAIL reset tx_err: got %b want 0", tx_err); end
        checks++; if (seq !== 16'h0) begin errors++; $display("FAIL reset seq: got %0d want 0", seq); end
        eth_clk_en = 1'b0;
        frm_req    = 1'b0;
    endtask

    task automatic test_single_req();
        int r;
        bit acked;
        logic [19:0] obs, want;
        r = int'($urandom_range(8, 3));
        do_reset();
        acked = 1'b0;
        while (t <= r + 45) begin
            obs  = obs_now();
            want = {t == r + 1, t == r + 1, t == r + 1 + BUSY_DLY + BUSY_LEN + NLP_SPACING, 1'b0,
                    (t >= r + 2) ? 16'd1 : 16'd0};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL single_req tick %0d: got start=%b ack=%b nlp=%b err=%b seq=%0d want start=%b ack=%b nlp=%b err=%b seq=%0d",
                         t, obs[19], obs[18], obs[17], obs[16], obs[15:0], want[19], want[18], want[17], want[16], want[15:0]);
            end
            if (frm_ack === 1'b1) acked = 1'b1;
            frm_req = (t >= r) && !acked;
            step(2);
        end
        frm_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [19:0] obs, want;
        bit s;
        do_reset();
        frm_req = 1'b1;
        while (t <= 100) begin
            s    = (t >= 2) && ((t - 2) % FRAME_PERIOD == 0);
            obs  = obs_now();
            want = {s, s, 1'b0, 1'b0, (t >= 3) ? 16'((t - 3) / FRAME_PERIOD + 1) : 16'd0};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL back_to_back tick %0d: got start=%b ack=%b nlp=%b err=%b seq=%0d want start=%b ack=%b nlp=%b err=%b seq=%0d",
                         t, obs[19], obs[18], obs[17], obs[16], obs[15:0], want[19], want[18], want[17], want[16], want[15:0]);
            end
            step(1);
        end
        frm_req = 1'b0;
    endtask

    task automatic test_nlp_idle();
        logic [19:0] obs, want;
        do_reset();
        while (t <= 70) begin
            obs  = obs_now();
            want = {1'b0, 1'b0, (t % NLP_SPACING) == 0, 1'b0, 16'd0};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL nlp_idle tick %0d: got start=%b ack=%b nlp=%b err=%b seq=%0d want start=%b ack=%b nlp=%b err=%b seq=%0d",
                         t, obs[19], obs[18], obs[17], obs[16], obs[15:0], want[19], want[18], want[17], want[16], want[15:0]);
            end
            step(2);
        end
    endtask

    task automatic test_nlp_collision();
        logic [19:0] obs, want;
        bit acked;
        int s_tick, m_tick;
        s_tick = NLP_SPACING;
        m_tick = s_tick + BUSY_DLY + BUSY_LEN;
        do_reset();
        acked = 1'b0;
        while (t <= 70) begin
            obs  = obs_now();
            want = {t == s_tick, t == s_tick, t == m_tick + NLP_SPACING, 1'b0,
                    (t > s_tick) ? 16'd1 : 16'd0};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL nlp_collision tick %0d: got start=%b ack=%b nlp=%b err=%b seq=%0d want start=%b ack=%b nlp=%b err=%b seq=%0d",
                         t, obs[19], obs[18], obs[17], obs[16], obs[15:0], want[19], want[18], want[17], want[16], want[15:0]);
            end
            if (frm_ack === 1'b1) acked = 1'b1;
            frm_req = (t >= s_tick - 1) && !acked;
            step(1);
        end
        frm_req = 1'b0;
    endtask

    task automatic test_busy_timeout();
        logic [19:0] obs, want;
        bit s;
        do_reset();
        xmit_on = 1'b0;
        frm_req = 1'b1;
        while (t <= 40) begin
            s    = (t >= 2) && ((t - 2) % TMO_PERIOD == 0);
            obs  = obs_now();
            want = {s, s, 1'b0, t >= 2 + BTO, (t >= 3) ? 16'((t - 3) / TMO_PERIOD + 1) : 16'd0};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL busy_timeout tick %0d: got start=%b ack=%b nlp=%b err=%b seq=%0d want start=%b ack=%b nlp=%b err=%b seq=%0d",
                         t, obs[19], obs[18], obs[17], obs[16], obs[15:0], want[19], want[18], want[17], want[16], want[15:0]);
            end
            step(2);
        end
        frm_req = 1'b0;
        xmit_on = 1'b1;
    endtask

    task automatic test_reset_mid_busy();
        logic [19:0] obs, want;
        bit acked;
        do_reset();
        acked = 1'b0;
        while (t < 8) begin
            if (frm_ack === 1'b1) acked = 1'b1;
            frm_req = !acked;
            step(0);
        end
        checks++;
        if (seq !== 16'd1) begin errors++; $display("FAIL mid_busy pre-reset seq: got %0d want 1", seq); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_now() !== 20'h0) begin errors++; $display("FAIL mid_busy async reset outputs: got %h want 00000", obs_now()); end
        eth_clk_en = 1'b1;
        frm_req    = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_now() !== 20'h0) begin errors++; $display("FAIL mid_busy held reset outputs: got %h want 00000", obs_now()); end
        rst_n      = 1'b1;
        eth_clk_en = 1'b0;
        frm_req    = 1'b0;
        tx_busy    = 1'b0;
        t          = 1;
        last_start = -100;
        acked      = 1'b0;
        while (t <= 6) begin
            obs  = obs_now();
            want = {t == 2, t == 2, 1'b0, 1'b0, (t >= 3) ? 16'd1 : 16'd0};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL mid_busy restart tick %0d: got start=%b ack=%b nlp=%b err=%b seq=%0d want start=%b ack=%b nlp=%b err=%b seq=%0d",
                         t, obs[19], obs[18], obs[17], obs[16], obs[15:0], want[19], want[18], want[17], want[16], want[15:0]);
            end
            if (frm_ack === 1'b1) acked = 1'b1;
            frm_req = !acked;
            step(0);
        end
        frm_req = 1'b0;
    endtask

    task automatic test_clk_en_hold();
        logic [19:0] obs, want;
        bit acked;
        do_reset();
        acked = 1'b0;
        while (t <= 40) begin
            obs  = obs_now();
            want = {t == 2, t == 2, t == 2 + BUSY_DLY + BUSY_LEN + NLP_SPACING, 1'b0,
                    (t >= 3) ? 16'd1 : 16'd0};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL en_hold tick %0d: got start=%b ack=%b nlp=%b err=%b seq=%0d want start=%b ack=%b nlp=%b err=%b seq=%0d",
                         t, obs[19], obs[18], obs[17], obs[16], obs[15:0], want[19], want[18], want[17], want[16], want[15:0]);
            end
            if (frm_ack === 1'b1) acked = 1'b1;
            if (t == 2) begin
                for (int i = 0; i < 50; i++) begin
                    eth_clk_en = 1'b0;
                    frm_req    = 1'($urandom);
                    tx_busy    = 1'($urandom);
                    @(negedge clk);
                    checks++;
                    if (obs_now() !== {1'b1, 1'b1, 1'b0, 1'b0, 16'd0}) begin
                        errors++;
                        $display("FAIL en_hold frozen clk %0d: got %h want c0000", i, obs_now());
                    end
                end
            end
            frm_req = !acked;
            step(1);
        end
        frm_req = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        eth_clk_en = 1'b0;
        frm_req    = 1'b0;
        tx_busy    = 1'b0;
        t          = 0;
        last_start = -100;
        xmit_on    = 1'b1;
        test_reset();
        test_single_req();
        test_back_to_back();
        test_nlp_idle();
        test_nlp_collision();
        test_busy_timeout();
        test_reset_mid_busy();
        test_clk_en_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit scheduler for the 10BASE-T output path. It sits between the audio `sender` framing logic and the Manchester `eth_tx` transmitter, in the `eth_clk_en` (10 MHz bit-tick) domain. It accepts frame requests through a req/ack handshake and issues the transmitter's single-tick `start` pulse. It enforces the 96-bit-time inter-frame gap and emits Normal Link Pulses (NLP) when the line has been idle for 16 ms, so the link stays up between audio frames.

## Interface
- `IFG_TICKS`, 96: inter-frame gap in bit ticks, counted after `tx_busy` falls.
- `NLP_PERIOD`, 160000: idle ticks between link pulses (16 ms at 10 MHz).
- `BUSY_TIMEOUT`, 8: ticks allowed for `tx_busy` to rise after `tx_start`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset. It is asynchronous and active-low.
- `eth_clk_en` in 1: bit-tick enable. All state advances only on `clk` edges where this is high.
- `frm_req` in 1: a frame is ready. Held high until `frm_ack`.
- `tx_busy` in 1: `eth_tx` is transmitting (preamble through end-of-frame).
- `tx_start` out 1: start pulse to `eth_tx`, one tick wide.
- `frm_ack` out 1: request accepted, one tick wide, coincident with `tx_start`.
- `nlp` out 1: link pulse, one tick wide (100 ns). It is ORed onto the line by the top level.
- `seq` out 16: frame sequence number.
- `tx_err` out 1: sticky flag, set on busy timeout.

## Operation
- A "tick" is one `clk` edge with `eth_clk_en`=1. Outputs are registered and held constant between ticks.
- Reset (`rst_n`=0, asynchronous) puts all outputs at 0, `state`=IDLE, `seq`=0, and clears the NLP timer, gap counter and timeout counter.
- FSM states:
  - IDLE:
    - If `frm_req`=1, go to START. A frame wins over a pending NLP.
    - Otherwise, if the NLP timer is expired, go to NLP.
    - Otherwise, stay in IDLE.
  - START: lasts one tick, with `tx_start`=`frm_ack`=1. `seq` increments (wrap 0xFFFF->0x0000). The NLP timer clears. Next state is WAIT_BUSY.
  - WAIT_BUSY:
    - When `tx_busy`=1, go to BUSY.
    - After `BUSY_TIMEOUT` ticks without `tx_busy`, set `tx_err`=1 and go to GAP.
  - BUSY: when `tx_busy`=0, go to GAP.
  - GAP: counts `IFG_TICKS` ticks, then goes to IDLE. `frm_req` is ignored here.
  - NLP: lasts one tick with `nlp`=1. The NLP timer clears. Next state is IDLE.
- NLP timer (18 bits):
  - Increments every tick in IDLE and GAP.
  - Holds in START, WAIT_BUSY and BUSY, then clears on exit from BUSY.
  - Is expired when it reaches `NLP_PERIOD`-1. It saturates there until an NLP or START clears it.
- `tx_err` clears only on reset.
- Dropping `frm_req` before ack is not allowed. If it happens outside IDLE, it has no effect.

## Timing
- Request latency: `frm_req` sampled high in IDLE at tick N gives `tx_start`/`frm_ack` high during tick N+1.
- `seq` shows its incremented value from tick N+2 onward. The value visible during the ack tick is the previous frame's number.
- Back-to-back frames:
  - If `tx_busy` is first seen low at tick M, the scheduler is in IDLE at M+IFG_TICKS+1.
  - The next `tx_start` is at M+IFG_TICKS+2.
- NLP spacing on an idle line is `NLP_PERIOD`+1 ticks from `nlp` to `nlp`.
- Simultaneous events:
  - `frm_req` and NLP expiry in the same IDLE tick: the frame is sent and the NLP is cancelled (timer cleared).
  - `frm_req` rising during the `nlp` tick: it is served from IDLE on the following tick.
- Reset mid-frame:
  - Outputs drop to 0 immediately.
  - On release the FSM is in IDLE with no gap enforced. The top level must also reset `eth_tx`.
- Ticks with `eth_clk_en`=0 change nothing, including the counters.

## Test plan
Use `IFG_TICKS`=4, `NLP_PERIOD`=20, `BUSY_TIMEOUT`=3, and a model transmitter that raises `tx_busy` 2 ticks after start for 10 ticks.
- Reset, then `frm_req`=1 at tick 5. Required:
  - `tx_start`/`frm_ack` high at tick 6 only.
  - `seq`=1 from tick 7.
  - No further `tx_start` while `frm_req` is low.
- `frm_req` held high permanently. Required:
  - Successive `tx_start` pulses exactly 2+10+4+2=18 ticks apart.
  - `seq` counts 1,2,3,….
  - `nlp` never asserts.
- Idle line after reset. Required: `nlp` pulses at ticks 21, 42, 63, each 1 tick wide, with `tx_start`=0 throughout.
- `frm_req` asserted on the exact tick the NLP timer expires. Required:
  - `tx_start` next tick, no `nlp`.
  - The next `nlp` comes no earlier than 21 ticks after `tx_busy` falls.
- Transmitter model never raises `tx_busy`. Required:
  - `tx_err`=1 three ticks after `tx_start`.
  - The next start comes 4 gap ticks later, and `tx_err` stays 1.
- `rst_n` low for 1 `clk` mid-BUSY, and `eth_clk_en` held low for 50 clks. Required:
  - All outputs and `seq` are 0 immediately on reset.
  - Nothing changes while the enable is low.
